stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: edge-detected start/stop/lap/clr requests drive a
// four-state FSM (IDLE, RUN, PAUSE, SAT). A prescaler divides RUN cycles by
// TICK_DIV, and each prescaler wrap increments a saturating elapsed count.
// Lap captures are reported through a one-cycle lap_valid pulse.
// All outputs come straight from registers.
module stopwatch_ctrl #(
    parameter int WIDTH     = 8,
    parameter int TICK_DIV  = 4,
    parameter int MAX_COUNT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             lap,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] lap_time,
    output logic             lap_valid,
    output logic             running,
    output logic             ovf,
    output logic [1:0]       state
);

    // The prescaler needs at least one bit, even when TICK_DIV is 1.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] COUNT_MAX  = WIDTH'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_SAT   = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] lap_time_q, lap_time_d;
    logic             lap_valid_q, lap_valid_d;
    logic             running_q, running_d;
    logic             ovf_q, ovf_d;

    // Previous-value registers used for press detection.
    logic start_prev_q;
    logic stop_prev_q;
    logic lap_prev_q;
    logic clr_prev_q;

    logic start_press_s;
    logic stop_press_s;
    logic lap_press_s;
    logic clr_press_s;
    logic tick_s;

    // A press is a 0->1 transition seen at this edge. Holding a level high
    // therefore produces only a single press.
    assign start_press_s = start & ~start_prev_q;
    assign stop_press_s  = stop  & ~stop_prev_q;
    assign lap_press_s   = lap   & ~lap_prev_q;
    assign clr_press_s   = clr   & ~clr_prev_q;

    // The prescaler wraps on this cycle. With TICK_DIV=1 this is always true.
    assign tick_s = (presc_q == PRESC_LAST);

    // Next-state logic: clr overrides everything, then per-state handling in
    // the order stop > start > lap, so an illegal higher press never masks
    // a legal lower one.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        presc_d     = presc_q;
        lap_time_d  = lap_time_q;
        lap_valid_d = 1'b0;

        if (clr_press_s) begin
            state_d    = ST_IDLE;
            count_d    = {WIDTH{1'b0}};
            presc_d    = {PW{1'b0}};
            lap_time_d = {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = {WIDTH{1'b0}};
                    presc_d = {PW{1'b0}};
                    if (start_press_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_RUN: begin
                    if (stop_press_s) begin
                        // Freeze count and prescaler exactly as they are.
                        state_d = ST_PAUSE;
                    end else begin
                        if (lap_press_s) begin
                            lap_time_d  = count_q;
                            lap_valid_d = 1'b1;
                        end else begin
                            lap_valid_d = 1'b0;
                        end
                        if (tick_s) begin
                            presc_d = {PW{1'b0}};
                            if (count_q == COUNT_MAX) begin
                                // Saturate instead of wrapping.
                                state_d = ST_SAT;
                            end else begin
                                count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
                        end
                    end
                end

                ST_PAUSE: begin
                    // Resume keeps the held prescaler phase. There is no
                    // increment on the resume edge itself.
                    if (start_press_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end

                ST_SAT: begin
                    count_d = COUNT_MAX;
                    if (lap_press_s) begin
                        lap_time_d  = COUNT_MAX;
                        lap_valid_d = 1'b1;
                    end else begin
                        lap_valid_d = 1'b0;
                    end
                end

                default: begin
                    state_d    = ST_IDLE;
                    count_d    = {WIDTH{1'b0}};
                    presc_d    = {PW{1'b0}};
                    lap_time_d = {WIDTH{1'b0}};
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        ovf_d     = (state_d == ST_SAT);
    end

    // State, datapath and previous-value registers, cleared asynchronously
    // by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= {WIDTH{1'b0}};
            presc_q      <= {PW{1'b0}};
            lap_time_q   <= {WIDTH{1'b0}};
            lap_valid_q  <= 1'b0;
            running_q    <= 1'b0;
            ovf_q        <= 1'b0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            lap_prev_q   <= 1'b0;
            clr_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            presc_q      <= presc_d;
            lap_time_q   <= lap_time_d;
            lap_valid_q  <= lap_valid_d;
            running_q    <= running_d;
            ovf_q        <= ovf_d;
            start_prev_q <= start;
            stop_prev_q  <= stop;
            lap_prev_q   <= lap;
            clr_prev_q   <= clr;
        end
    end

    assign count     = count_q;
    assign lap_time  = lap_time_q;
    assign lap_valid = lap_valid_q;
    assign running   = running_q;
    assign ovf       = ovf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl. Three instances share the stimulus:
// the default configuration, a TICK_DIV=1 variant, and a MAX_COUNT=10 variant.
module tb_stopwatch_ctrl;

    logic clk;
    logic rst;
    logic start;
    logic stop;
    logic lap;
    logic clr;

    logic [7:0] count, lap_time;
    logic       lap_valid, running, ovf;
    logic [1:0] state;

    logic [7:0] t1_count, t1_lap_time;
    logic       t1_lap_valid, t1_running, t1_ovf;
    logic [1:0] t1_state;

    logic [7:0] sat_count, sat_lap_time;
    logic       sat_lap_valid, sat_running, sat_ovf;
    logic [1:0] sat_state;

    int errors = 0;
    int checks = 0;
    int pulses_main;
    int pulses_sat;

    typedef struct {
        logic       st;
        logic       sp;
        logic       lp;
        logic       cl;
        int         n;
        int         ecnt;
        logic [1:0] est;
        logic       elv;
        int         elt;
        int         epulse;
    } vec_t;

    vec_t vq[$];

    stopwatch_ctrl #(.WIDTH(8), .TICK_DIV(4), .MAX_COUNT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .lap(lap), .clr(clr),
        .count(count), .lap_time(lap_time), .lap_valid(lap_valid),
        .running(running), .ovf(ovf), .state(state)
    );

    stopwatch_ctrl #(.WIDTH(8), .TICK_DIV(1), .MAX_COUNT(255)) dut_t1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .lap(lap), .clr(clr),
        .count(t1_count), .lap_time(t1_lap_time), .lap_valid(t1_lap_valid),
        .running(t1_running), .ovf(t1_ovf), .state(t1_state)
    );

    stopwatch_ctrl #(.WIDTH(8), .TICK_DIV(4), .MAX_COUNT(10)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .lap(lap), .clr(clr),
        .count(sat_count), .lap_time(sat_lap_time), .lap_valid(sat_lap_valid),
        .running(sat_running), .ovf(sat_ovf), .state(sat_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic lp, input logic cl,
                       input int n, input int ecnt, input logic [1:0] est,
                       input logic elv, input int elt, input int epulse);
        vec_t v;
        v.st = st; v.sp = sp; v.lp = lp; v.cl = cl; v.n = n;
        v.ecnt = ecnt; v.est = est; v.elv = elv; v.elt = elt; v.epulse = epulse;
        vq.push_back(v);
    endtask

    // Called at a negedge: hold inputs for n rising edges, sampling at each negedge.
    task automatic drive(input logic st, input logic sp, input logic lp, input logic cl,
                         input int n);
        start = st; stop = sp; lap = lp; clr = cl;
        pulses_main = 0;
        pulses_sat  = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (lap_valid === 1'b1) pulses_main++;
            if (sat_lap_valid === 1'b1) pulses_sat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        drive(v.st, v.sp, v.lp, v.cl, v.n);
        chk({tag, " count"}, int'(count), v.ecnt);
        chk({tag, " state"}, int'(state), int'(v.est));
        chk({tag, " running"}, int'(running), (v.est == 2'b01) ? 1 : 0);
        chk({tag, " ovf"}, int'(ovf), (v.est == 2'b11) ? 1 : 0);
        chk({tag, " lap_valid"}, int'(lap_valid), int'(v.elv));
        chk({tag, " lap_time"}, int'(lap_time), v.elt);
        chk({tag, " lv_pulses"}, pulses_main, v.epulse);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; start = 1'b0; stop = 1'b0; lap = 1'b0; clr = 1'b0;

        //   st    sp    lp    cl    n   cnt st     lv    lt pulses
        add(1'b1, 1'b0, 1'b0, 1'b0,  1, 0, 2'b01, 1'b0, 0, 0); // start press
        add(1'b0, 1'b0, 1'b0, 1'b0, 20, 5, 2'b01, 1'b0, 0, 0); // run 20 cycles
        add(1'b0, 1'b0, 1'b0, 1'b0,  2, 5, 2'b01, 1'b0, 0, 0); // prescaler -> 2
        add(1'b0, 1'b1, 1'b0, 1'b0,  1, 5, 2'b10, 1'b0, 0, 0); // stop
        add(1'b0, 1'b1, 1'b0, 1'b0, 40, 5, 2'b10, 1'b0, 0, 0); // hold PAUSE
        add(1'b1, 1'b0, 1'b0, 1'b0,  1, 5, 2'b01, 1'b0, 0, 0); // resume edge
        add(1'b0, 1'b0, 1'b0, 1'b0,  1, 5, 2'b01, 1'b0, 0, 0); // +1: no tick yet
        add(1'b0, 1'b0, 1'b0, 1'b0,  1, 6, 2'b01, 1'b0, 0, 0); // +2: count 6
        add(1'b0, 1'b0, 1'b0, 1'b0,  4, 7, 2'b01, 1'b0, 0, 0); // count 7
        add(1'b0, 1'b0, 1'b1, 1'b0,  1, 7, 2'b01, 1'b1, 7, 1); // lap press
        add(1'b0, 1'b0, 1'b1, 1'b0,  1, 7, 2'b01, 1'b0, 7, 0); // lap held
        add(1'b0, 1'b0, 1'b1, 1'b0,  8, 9, 2'b01, 1'b0, 7, 0); // lap held on
        add(1'b0, 1'b0, 1'b0, 1'b0,  1, 9, 2'b01, 1'b0, 7, 0); // prescaler 3
        add(1'b0, 1'b1, 1'b0, 1'b0,  1, 9, 2'b10, 1'b0, 7, 0); // pause
        add(1'b1, 1'b0, 1'b0, 1'b1,  1, 0, 2'b00, 1'b0, 0, 0); // start+clr
        add(1'b0, 1'b0, 1'b0, 1'b0,  3, 0, 2'b00, 1'b0, 0, 0); // idle holds 0
        add(1'b1, 1'b0, 1'b0, 1'b0,  1, 0, 2'b01, 1'b0, 0, 0); // start
        add(1'b0, 1'b0, 1'b0, 1'b0,  5, 1, 2'b01, 1'b0, 0, 0); // count 1
        add(1'b0, 1'b0, 1'b1, 1'b0,  1, 1, 2'b01, 1'b1, 1, 1); // lap -> 1
        add(1'b0, 1'b0, 1'b0, 1'b0,  1, 1, 2'b01, 1'b0, 1, 0); // prescaler 3
        add(1'b0, 1'b1, 1'b1, 1'b0,  1, 1, 2'b10, 1'b0, 1, 0); // stop+lap
        add(1'b0, 1'b0, 1'b0, 1'b0,  2, 1, 2'b10, 1'b0, 1, 0); // stays paused
        add(1'b0, 1'b0, 1'b1, 1'b0,  2, 1, 2'b10, 1'b0, 1, 0); // lap in PAUSE
        add(1'b0, 1'b1, 1'b0, 1'b0,  1, 1, 2'b10, 1'b0, 1, 0); // stop in PAUSE
        add(1'b1, 1'b0, 1'b0, 1'b0,  1, 1, 2'b01, 1'b0, 1, 0); // resume at 3
        add(1'b0, 1'b0, 1'b0, 1'b0,  1, 2, 2'b01, 1'b0, 1, 0); // immediate tick
        add(1'b1, 1'b0, 1'b0, 1'b0,  1, 2, 2'b01, 1'b0, 1, 0); // start in RUN
        add(1'b0, 1'b0, 1'b0, 1'b0,  4, 3, 2'b01, 1'b0, 1, 0); // count 3

        // Reset state while rst is held.
        @(negedge clk);
        @(negedge clk);
        chk("reset count", int'(count), 0);
        chk("reset state", int'(state), 0);
        chk("reset lap_time", int'(lap_time), 0);
        chk("reset flags", int'({lap_valid, running, ovf}), 0);
        rst = 1'b0;

        foreach (vq[i]) begin
            run_vec(vq[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset between edges, mid-RUN with count=3.
        #2 rst = 1'b1;
        #1;
        chk("async count", int'(count), 0);
        chk("async state", int'(state), 0);
        chk("async lap_time", int'(lap_time), 0);
        chk("async flags", int'({lap_valid, running, ovf}), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6);
        chk("post-rst count", int'(count), 0);
        chk("post-rst state", int'(state), 0);

        // Start held through reset release is a press at the first edge.
        start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk("held-start state", int'(state), 1);
        chk("held-start running", int'(running), 1);

        // TICK_DIV=1 counts every RUN cycle; TICK_DIV=4 only once in 5 edges.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5);
        chk("t1 count", int'(t1_count), 5);
        chk("t1 state", int'(t1_state), 1);
        chk("t4 count", int'(count), 1);

        // Saturation with MAX_COUNT=10.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 40);
        chk("sat pre count", int'(sat_count), 10);
        chk("sat pre state", int'(sat_state), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4);
        chk("sat count", int'(sat_count), 10);
        chk("sat state", int'(sat_state), 3);
        chk("sat ovf", int'(sat_ovf), 1);
        chk("sat running", int'(sat_running), 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1);
        chk("sat lap_time", int'(sat_lap_time), 10);
        chk("sat lap_valid", int'(sat_lap_valid), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk("sat start state", int'(sat_state), 3);
        chk("sat start count", int'(sat_count), 10);
        chk("sat lv drop", int'(sat_lap_valid), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
        chk("sat stop state", int'(sat_state), 3);
        chk("sat stop count", int'(sat_count), 10);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
        chk("sat clr state", int'(sat_state), 0);
        chk("sat clr count", int'(sat_count), 0);
        chk("sat clr ovf", int'(sat_ovf), 0);
        chk("sat clr lap_time", int'(sat_lap_time), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8);
        chk("sat idle count", int'(sat_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
